// File: rtl/alu_pkg.sv
// Shared constants for the MIPS32 ALU: datapath width and aluc operation codes.
package alu_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [OP_W-1:0] ALU_ADDU = 5'b00000;
  localparam logic [OP_W-1:0] ALU_SUBU = 5'b00001;
  localparam logic [OP_W-1:0] ALU_SLT  = 5'b00010;
  localparam logic [OP_W-1:0] ALU_AND  = 5'b00011;
  localparam logic [OP_W-1:0] ALU_NOR  = 5'b00100;
  localparam logic [OP_W-1:0] ALU_OR   = 5'b00101;
  localparam logic [OP_W-1:0] ALU_XOR  = 5'b00110;
  localparam logic [OP_W-1:0] ALU_SLL  = 5'b00111;
  localparam logic [OP_W-1:0] ALU_SRL  = 5'b01000;
  localparam logic [OP_W-1:0] ALU_SLTU = 5'b01001;
  localparam logic [OP_W-1:0] ALU_JALR = 5'b01010;
  localparam logic [OP_W-1:0] ALU_JR   = 5'b01011;
  localparam logic [OP_W-1:0] ALU_SLLV = 5'b01100;
  localparam logic [OP_W-1:0] ALU_SRA  = 5'b01101;
  localparam logic [OP_W-1:0] ALU_SRAV = 5'b01110;
  localparam logic [OP_W-1:0] ALU_SRLV = 5'b01111;
  localparam logic [OP_W-1:0] ALU_LUI  = 5'b10000;
  localparam logic [OP_W-1:0] ALU_BGEZ = 5'b10001;
  localparam logic [OP_W-1:0] ALU_BGTZ = 5'b10010;
  localparam logic [OP_W-1:0] ALU_BLEZ = 5'b10011;
  localparam logic [OP_W-1:0] ALU_BLTZ = 5'b10100;

endpackage

// File: rtl/mips_alu_if.sv
// Operand/control inputs and registered result/flags of the ALU.
interface mips_alu_if;
  import alu_pkg::*;

  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [OP_W-1:0]    aluc;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   r;
  logic               zero;
  logic               carry;
  logic               overflow;

  modport master (output a, b, aluc, shamt, input r, zero, carry, overflow);
  modport slave  (input a, b, aluc, shamt, output r, zero, carry, overflow);
endinterface

// File: rtl/alu_shifter.sv
// Combinational barrel shifter; out_bit is the last bit shifted out (0 for amount 0).
module alu_shifter
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] amount,
  input  logic               left,
  input  logic               arith,
  output logic [WIDTH-1:0]   result,
  output logic               out_bit
);

  logic [WIDTH:0]        lsh;
  logic [WIDTH:0]        lrs;
  logic signed [WIDTH:0] ars;
  logic [WIDTH:0]        rsh;

  // One guard bit on each side catches the shifted-out bit.
  assign lsh = {1'b0, data} << amount;
  assign lrs = {data, 1'b0} >> amount;
  assign ars = $signed({data, 1'b0}) >>> amount;
  assign rsh = arith ? $unsigned(ars) : lrs;

  assign result  = left ? lsh[WIDTH-1:0] : rsh[WIDTH:1];
  assign out_bit = left ? lsh[WIDTH]     : rsh[0];

endmodule

// File: rtl/mips_alu.sv
// MIPS32 ALU: add/sub, logic, compare, shifts and branch tests with one registered output stage.
module mips_alu
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  mips_alu_if.slave  bus
);

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [SHAMT_W-1:0]   sh_amt;
  logic                 sh_left;
  logic                 sh_arith;
  logic [WIDTH-1:0]     sh_res;
  logic                 sh_out;
  logic [WIDTH-1:0]     r_nxt;
  logic                 c_nxt;
  logic                 v_nxt;
  logic                 a_neg;
  logic                 a_zero;

  logic [WIDTH-1:0]     r_q;
  logic                 zero_q;
  logic                 carry_q;
  logic                 overflow_q;

  // diff[WIDTH] is the unsigned borrow, i.e. a < b.
  assign sum    = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff   = {1'b0, bus.a} - {1'b0, bus.b};
  assign a_neg  = bus.a[WIDTH-1];
  assign a_zero = (bus.a == '0);

  // Shifter steering: variable shifts take their amount from a[4:0].
  always_comb begin
    sh_amt   = bus.shamt;
    sh_left  = 1'b0;
    sh_arith = 1'b0;
    case (bus.aluc)
      ALU_SLL:  sh_left = 1'b1;
      ALU_SLLV: begin sh_left = 1'b1; sh_amt = bus.a[SHAMT_W-1:0]; end
      ALU_SRLV: sh_amt = bus.a[SHAMT_W-1:0];
      ALU_SRA:  sh_arith = 1'b1;
      ALU_SRAV: begin sh_arith = 1'b1; sh_amt = bus.a[SHAMT_W-1:0]; end
      default:  ;
    endcase
  end

  alu_shifter u_shifter (
    .data    (bus.b),
    .amount  (sh_amt),
    .left    (sh_left),
    .arith   (sh_arith),
    .result  (sh_res),
    .out_bit (sh_out)
  );

  // Result mux and flag generation.
  always_comb begin
    r_nxt = '0;
    c_nxt = 1'b0;
    v_nxt = 1'b0;
    case (bus.aluc)
      ALU_ADDU: begin
        r_nxt = sum[WIDTH-1:0];
        c_nxt = sum[WIDTH];
        v_nxt = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      ALU_SUBU: begin
        r_nxt = diff[WIDTH-1:0];
        c_nxt = diff[WIDTH];
        v_nxt = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      ALU_SLT:  r_nxt = WIDTH'($signed(bus.a) < $signed(bus.b));
      ALU_SLTU: begin
        r_nxt = WIDTH'(diff[WIDTH]);
        c_nxt = diff[WIDTH];
      end
      ALU_AND:  r_nxt = bus.a & bus.b;
      ALU_NOR:  r_nxt = ~(bus.a | bus.b);
      ALU_OR:   r_nxt = bus.a | bus.b;
      ALU_XOR:  r_nxt = bus.a ^ bus.b;
      ALU_SLL, ALU_SRL, ALU_SLLV, ALU_SRA, ALU_SRAV, ALU_SRLV: begin
        r_nxt = sh_res;
        c_nxt = sh_out;
      end
      ALU_JALR, ALU_JR: r_nxt = bus.a;
      ALU_LUI:  r_nxt = {bus.b[WIDTH/2-1:0], (WIDTH/2)'(0)};
      ALU_BGEZ: r_nxt = WIDTH'(!a_neg);
      ALU_BGTZ: r_nxt = WIDTH'(!a_neg && !a_zero);
      ALU_BLEZ: r_nxt = WIDTH'(a_neg || a_zero);
      ALU_BLTZ: r_nxt = WIDTH'(a_neg);
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q        <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      r_q        <= r_nxt;
      zero_q     <= (r_nxt == '0);
      carry_q    <= c_nxt;
      overflow_q <= v_nxt;
    end
  end

  assign bus.r        = r_q;
  assign bus.zero     = zero_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed corner cases plus random ops against a reference model.
module tb_mips_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  mips_alu_if bus ();

  mips_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model from the arithmetic definition of each operation.
  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] op, input logic [4:0] sh,
                                  output logic [31:0] r, output logic c, output logic v);
    longint          sa, sb, s;
    longint unsigned u;
    int              n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'h0; c = 1'b0; v = 1'b0;
    n = (op == 5'd12 || op == 5'd14 || op == 5'd15) ? int'(a[4:0]) : int'(sh);
    case (op)
      5'd0: begin
        u = longint'({32'h0, a}) + longint'({32'h0, b});
        r = u[31:0]; c = (u >= 64'h1_0000_0000);
        s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd1: begin
        r = a - b; c = (a < b);
        s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd2:  r = (sa < sb) ? 32'd1 : 32'd0;
      5'd3:  r = a & b;
      5'd4:  r = ~(a | b);
      5'd5:  r = a | b;
      5'd6:  r = a ^ b;
      5'd7, 5'd12: begin r = b << n; c = (n == 0) ? 1'b0 : b[32-n]; end
      5'd8, 5'd15: begin r = b >> n; c = (n == 0) ? 1'b0 : b[n-1]; end
      5'd13, 5'd14: begin r = 32'($signed(b) >>> n); c = (n == 0) ? 1'b0 : b[n-1]; end
      5'd9:  begin r = (a < b) ? 32'd1 : 32'd0; c = (a < b); end
      5'd10, 5'd11: r = a;
      5'd16: r = b * 32'h1_0000;
      5'd17: r = (sa >= 0) ? 32'd1 : 32'd0;
      5'd18: r = (sa > 0)  ? 32'd1 : 32'd0;
      5'd19: r = (sa <= 0) ? 32'd1 : 32'd0;
      5'd20: r = (sa < 0)  ? 32'd1 : 32'd0;
      default: r = 32'h0;
    endcase
  endfunction

  // Apply one operation, wait one edge, compare all outputs with the model.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] er;
    logic        ec, ev;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.aluc = op; bus.shamt = sh;
    ref_alu(a, b, op, sh, er, ec, ev);
    @(posedge clk);
    #1;
    check({tag, ".r"}, bus.r, er);
    check({tag, ".zero"}, 32'(bus.zero), 32'(er == 32'h0));
    check({tag, ".carry"}, 32'(bus.carry), 32'(ec));
    check({tag, ".ovf"}, 32'(bus.overflow), 32'(ev));
  endtask

  // Directed op with a hard-coded expected result as an independent cross-check.
  task automatic run_exp(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp_r);
    run_op(tag, op, a, b, sh);
    check({tag, ".const"}, bus.r, exp_r);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bus.a = '0; bus.b = '0; bus.aluc = '0; bus.shamt = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst0.r", bus.r, 32'h0);
    check("rst0.zero", 32'(bus.zero), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst0_hold.r", bus.r, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_exp("addu_pre", ALU_ADDU, 32'h1234_5678, 32'h1111_1111, 5'd0, 32'h2345_6789);

    // Asynchronous reset with the clock stopped.
    @(negedge clk);
    clk_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("arst.r", bus.r, 32'h0);
    check("arst.zero", 32'(bus.zero), 32'h0);
    check("arst.carry", 32'(bus.carry), 32'h0);
    check("arst.ovf", 32'(bus.overflow), 32'h0);
    #10 rst_n = 1'b1;
    #3 clk_en = 1'b1;

    run_exp("addu_3_1", ALU_ADDU, 32'd3, 32'd1, 5'd0, 32'd4);
    run_exp("addu_wrap", ALU_ADDU, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0);
    run_exp("addu_ovf", ALU_ADDU, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000);
    check("addu_ovf.flag", 32'(bus.overflow), 32'd1);
    run_exp("subu", ALU_SUBU, 32'd3, 32'd1, 5'd0, 32'd2);
    run_exp("subu_borrow", ALU_SUBU, 32'd1, 32'd3, 5'd0, 32'hFFFF_FFFE);
    run_exp("subu_ovf", ALU_SUBU, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF);
    run_exp("and", ALU_AND, 32'd3, 32'd1, 5'd0, 32'd1);
    run_exp("or", ALU_OR, 32'd3, 32'd1, 5'd0, 32'd3);
    run_exp("xor", ALU_XOR, 32'd3, 32'd1, 5'd0, 32'd2);
    run_exp("nor", ALU_NOR, 32'd3, 32'd1, 5'd0, 32'hFFFF_FFFC);
    run_exp("slt", ALU_SLT, 32'd3, 32'd1, 5'd0, 32'd0);
    run_exp("sltu", ALU_SLTU, 32'd3, 32'd1, 5'd0, 32'd0);
    run_exp("slt_neg", ALU_SLT, 32'hFFFF_FFF3, 32'd1, 5'd0, 32'd1);
    run_exp("sltu_neg", ALU_SLTU, 32'hFFFF_FFF3, 32'd1, 5'd0, 32'd0);
    run_exp("sll", ALU_SLL, 32'd0, 32'hFFFF_FFF1, 5'd4, 32'hFFFF_FF10);
    run_exp("srl", ALU_SRL, 32'd0, 32'hFFFF_FFF1, 5'd4, 32'h0FFF_FFFF);
    run_exp("sra", ALU_SRA, 32'd0, 32'hFFFF_FFF1, 5'd4, 32'hFFFF_FFFF);
    run_exp("sllv", ALU_SLLV, 32'd3, 32'hFFFF_FFF1, 5'd0, 32'hFFFF_FF88);
    run_exp("srlv", ALU_SRLV, 32'd3, 32'hFFFF_FFF1, 5'd0, 32'h1FFF_FFFE);
    run_exp("srav", ALU_SRAV, 32'd3, 32'hFFFF_FFF1, 5'd0, 32'hFFFF_FFFE);
    run_exp("sllv_hi_a", ALU_SLLV, 32'hFFFF_FFE3, 32'hFFFF_FFF1, 5'd0, 32'hFFFF_FF88);
    run_exp("sll_0", ALU_SLL, 32'd0, 32'h8000_0001, 5'd0, 32'h8000_0001);
    run_exp("sra_0", ALU_SRA, 32'd0, 32'h8000_0001, 5'd0, 32'h8000_0001);
    run_exp("srl_31", ALU_SRL, 32'd0, 32'hC000_0000, 5'd31, 32'd1);
    run_exp("lui", ALU_LUI, 32'd0, 32'd1, 5'd0, 32'h0001_0000);
    run_exp("jr", ALU_JR, 32'd3, 32'd9, 5'd0, 32'd3);
    run_exp("jalr", ALU_JALR, 32'd3, 32'd9, 5'd0, 32'd3);
    run_exp("undef", 5'b11111, 32'd3, 32'd1, 5'd4, 32'd0);
    run_exp("bgez_neg", ALU_BGEZ, 32'hFFFF_FFF3, 32'd0, 5'd0, 32'd0);
    run_exp("bgtz_pos", ALU_BGTZ, 32'd3, 32'd0, 5'd0, 32'd1);
    run_exp("blez_neg", ALU_BLEZ, 32'hFFFF_FFF3, 32'd0, 5'd0, 32'd1);
    run_exp("bltz_pos", ALU_BLTZ, 32'd3, 32'd0, 5'd0, 32'd0);
    run_exp("bgez_0", ALU_BGEZ, 32'd0, 32'd0, 5'd0, 32'd1);
    run_exp("blez_0", ALU_BLEZ, 32'd0, 32'd0, 5'd0, 32'd1);
    run_exp("bgtz_0", ALU_BGTZ, 32'd0, 32'd0, 5'd0, 32'd0);

    for (int i = 0; i < 600; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h7FFF_FFFF;
        1: rb = 32'h8000_0000;
        2: ra = 32'h0;
        3: rb = ra;
        default: ;
      endcase
      run_op("rand", 5'($urandom_range(0, 31)), ra, rb, 5'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- 32-bit arithmetic/logic/shift/compare unit for a MIPS32 single-cycle CPU datapath.
- Operands come from the register file or the immediate mux.
- A 5-bit control code `aluc` from the control unit selects one of 21 operations.
- The result and status flags are registered and go to writeback, branch and jump logic.

Parameters:
- WIDTH, 32, datapath width (only 32 is required and verified).

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  reset; asynchronous, active-low.
- a  input  32  operand A (rs).
- b  input  32  operand B (rt or immediate).
- aluc  input  5  operation select.
- shamt  input  5  immediate shift amount.
- r  output  32  registered result.
- zero  output  1  registered; high when the next r is 0.
- carry  output  1  registered carry/borrow/shift-out flag.
- overflow  output  1  registered signed-overflow flag.

Behaviour:
- Clocking and reset:
  - rst_n low asynchronously forces r=0, zero=0, carry=0, overflow=0, regardless of clk.
  - While rst_n is low, outputs hold 0.
  - Release of rst_n takes effect at the next rising clk edge.
- Latency:
  - Inputs are sampled at each rising clk edge.
  - All four outputs update together at that edge: one-cycle latency, no handshake.
  - A new operation is accepted every cycle.
- Operations (aluc -> r):
  - 00000 addu: a+b
  - 00001 subu: a-b
  - 00010 slt: signed a<b ? 1 : 0
  - 00011 and: a&b
  - 00100 nor: ~(a|b)
  - 00101 or: a|b
  - 00110 xor: a^b
  - 00111 sll: b<<shamt
  - 01000 srl: b>>shamt (logical)
  - 01001 sltu: unsigned a<b ? 1 : 0
  - 01010 jalr: a
  - 01011 jr: a
  - 01100 sllv: b<<a[4:0]
  - 01101 sra: b>>>shamt (arithmetic)
  - 01110 srav: b>>>a[4:0]
  - 01111 srlv: b>>a[4:0]
  - 10000 lui: {b[15:0],16'h0}
  - 10001 bgez: a signed >=0 ? 1 : 0
  - 10010 bgtz: a signed >0 ? 1 : 0
  - 10011 blez: a signed <=0 ? 1 : 0
  - 10100 bltz: a signed <0 ? 1 : 0
  - 10101..11111: r=0, all flags 0
- Flags:
  - zero = (r==0) for every code, including undefined codes (zero=1 there).
  - carry, addu: bit 32 of the 33-bit sum.
  - carry, subu and sltu: unsigned borrow (a<b).
  - carry, left shifts: last bit shifted out, b[32-n].
  - carry, right shifts: b[n-1].
  - carry when the shift amount n=0: 0.
  - carry for all other codes: 0.
  - overflow, addu: set when a[31]==b[31] and sum[31]!=a[31].
  - overflow, subu: set when a[31]!=b[31] and diff[31]!=a[31].
  - overflow for all other codes: 0.
  - Overflow never suppresses or traps the result; r is always written.
- Boundaries:
  - Arithmetic wraps modulo 2^32.
  - Shift amount 0 returns b unchanged.
  - Variable shifts ignore a[31:5].

Decomposition:
- Shared package `alu_pkg` holds:
  - the 5-bit opcode localparams (ALU_ADDU..ALU_BLTZ);
  - the WIDTH constant.
- One natural sub-module, `alu_shifter`: combinational barrel shifter.
  - Inputs: data, amount, direction, arithmetic flag.
  - Outputs: shifted value and shift-out bit.
- The top level holds:
  - the add/sub adder;
  - logic and compare ops;
  - the result mux;
  - the output register stage.

Test Plan:
- Reset: drive rst_n=0 mid-operation with clk stopped -> r=0 and all flags 0 immediately. After release, addu a=3 b=1 -> r=4, zero=0, carry=0, overflow=0 one edge later.
- Add/sub wrap:
  - addu a=FFFFFFFF b=1 -> r=0, zero=1, carry=1.
  - addu a=7FFFFFFF b=1 -> r=80000000, overflow=1.
  - subu a=3 b=1 -> r=2.
- Logic and compare, a=3 b=1:
  - and -> 1; or -> 3; xor -> 2; nor -> FFFFFFFC.
  - slt -> 0; sltu -> 0.
  - slt a=FFFFFFF3 b=1 -> 1.
- Shifts with b=FFFFFFF1:
  - shamt=4: sll -> FFFFFF10; srl -> 0FFFFFFF; sra -> FFFFFFFF.
  - a=3: sllv -> FFFFFF88; srlv -> 1FFFFFFE; srav -> FFFFFFFE.
- Misc:
  - lui b=1 -> 00010000.
  - jr/jalr a=3 -> r=3.
  - undefined aluc=11111 -> r=0, zero=1.
- Branch compares:
  - bgez a=FFFFFFF3 -> r=0, zero=1.
  - bgtz a=3 -> r=1.
  - blez a=FFFFFFF3 -> r=1.
  - bltz a=3 -> r=0.
  - bgez and blez a=0 -> r=1.
  - bgtz a=0 -> r=0.
